mul_middle_issuer: RTL and testbench
====================================

Name: mul_middle_issuer

Overview:
Initiator and consumer for the 80x80 middle-bit multiplier (product bits [2*RADIX-1:RADIX]). It accepts operand pairs on a valid/ready stream and spaces the multiplier's single-cycle `en` pulses so its three-stage internal sequence is never overrun. It captures `res` after the fixed latency and returns it on a valid/ready output stream with a passthrough tag. It sits between the Barrett/modular datapath sequencer and the DSP multiplier instance.

Parameters:
MUL_SIZE, 80, operand width driven to the multiplier.
RADIX, 78, result width; must equal the multiplier's radix.
MUL_LAT, 3, number of clock edges from the multiplier sampling `en` until `res` is stable; legal range ≥2.
TAG_W, 4, width of the opaque tag carried with each operation.

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
in_valid  in  1  operand pair valid
in_ready  out  1  block can accept an operand pair this cycle
in_a  in  MUL_SIZE  operand a
in_b  in  MUL_SIZE  operand b
in_tag  in  TAG_W  request tag
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
out_res  out  RADIX  middle bits of in_a*in_b
out_tag  out  TAG_W  tag of that result
mul_rst_n  out  1  multiplier reset, combinational ~rst
mul_en  out  1  multiplier start pulse
mul_a  out  MUL_SIZE  multiplier operand a, registered
mul_b  out  MUL_SIZE  multiplier operand b, registered
mul_res  in  RADIX  multiplier result
busy  out  1  state != IDLE or out_valid

Behaviour:
- Reset, sync active-high: state=IDLE. Outputs reset to: out_valid=0, mul_en=0, mul_a=0, mul_b=0, out_res=0, out_tag=0, wait counter=0. mul_rst_n=0 while rst=1.
- in_ready = (state==IDLE) && (!out_valid || out_ready), combinational. A transfer occurs when in_valid && in_ready.
- FSM:
  - IDLE: on transfer, latch in_a/in_b into mul_a/mul_b, latch in_tag, go to ISSUE.
  - ISSUE (1 cycle): mul_en=1. Load the wait counter with MUL_LAT-2. Go to WAIT.
  - WAIT: mul_en=0. Decrement the counter each cycle. When the counter is 0, go to CAPTURE. WAIT lasts MUL_LAT-1 cycles.
  - CAPTURE (1 cycle): on the closing edge, register out_res<=mul_res, out_tag<=latched tag, out_valid<=1. Go to IDLE.
- Latency with MUL_LAT=3: transfer edge at end of cycle 0 → ISSUE in cycle 1 → WAIT in cycles 2–3 → CAPTURE in cycle 4 → out_valid high from cycle 5.
- Throughput: at most one operation per MUL_LAT+2 cycles.
- mul_en is never high in two cycles less than MUL_LAT+2 apart.
- mul_a/mul_b hold their values until the next transfer.
- Output slot: out_valid clears on out_valid && out_ready. out_res and out_tag stay stable while out_valid && !out_ready.
- Simultaneous out_ready and new transfer in IDLE: both take effect. The old result is consumed on that edge; the new result appears MUL_LAT+2 cycles later.
- Overflow cannot occur: a transfer requires the output slot to be free or draining.
- in_valid while not in IDLE: ignored. in_ready=0, so the upstream must hold its operands.
- rst asserted mid-operation: return to IDLE next edge. The in-flight result is discarded and out_valid=0. The multiplier is reset through mul_rst_n.
- Widths: no arithmetic is done here. out_res is mul_res bit-exact.

Optional Feature:
MUL_ISSUER_PERF_EN:
- Defined: adds output op_count (32 bits) and output stall_count (32 bits).
  - op_count increments on each CAPTURE.
  - stall_count increments each cycle that out_valid && !out_ready.
  - Both reset to 0 and wrap at 2^32.
- Undefined: neither port nor the counters exist.

Test Plan:
- Single op: a=2^78, b=1, tag=5 → exactly one mul_en pulse, one cycle after the transfer. out_valid rises 5 cycles after the transfer edge with out_res=1, out_tag=5.
- Top bit: a=2^79, b=2^76 → out_res=2^77. a=2^79, b=2^79 → out_res=0 (product bits lie outside [155:78]).
- All ones: a=b=2^80-1 → out_res=0x3FFF_FFFF_FFFF_FFFF_FFF8 (bits 3..77 set).
- Back-to-back with in_valid held high and out_ready=1, 4 ops:
  - mul_en pulses exactly 5 cycles apart.
  - in_ready is high only in IDLE.
  - Results return in order, tags 0..3.
- Backpressure: out_ready=0 for 10 cycles after the first result.
  - out_res/out_tag stay stable and in_ready=0.
  - Then raise out_ready together with in_valid: the result is consumed and the next op is accepted on the same edge.
- Reset during WAIT: assert rst for 1 cycle → out_valid=0, mul_en=0, mul_rst_n=0 during rst, state IDLE. No result is produced for the aborted op. The next op (a=2^78, b=1) returns 1.

Source files
------------

// File: rtl/mul_middle_issuer_if.sv
// Operand request and result response streams between the datapath sequencer
// and mul_middle_issuer. The slave modport is the issuer side.
interface mul_middle_issuer_if #(
  parameter int MUL_SIZE = 80,
  parameter int RADIX    = 78,
  parameter int TAG_W    = 4
);
  logic                in_valid;
  logic                in_ready;
  logic [MUL_SIZE-1:0] in_a;
  logic [MUL_SIZE-1:0] in_b;
  logic [TAG_W-1:0]    in_tag;

  logic                out_valid;
  logic                out_ready;
  logic [RADIX-1:0]    out_res;
  logic [TAG_W-1:0]    out_tag;

  modport master (
    output in_valid, in_a, in_b, in_tag, out_ready,
    input  in_ready, out_valid, out_res, out_tag
  );

  modport slave (
    input  in_valid, in_a, in_b, in_tag, out_ready,
    output in_ready, out_valid, out_res, out_tag
  );
endinterface

// File: rtl/mul_middle_issuer.sv
// Issues one operation at a time to the middle-bit multiplier and returns its result.
// Optional MUL_ISSUER_PERF_EN adds op_count/stall_count performance counters.
module mul_middle_issuer #(
  parameter int MUL_SIZE = 80,
  parameter int RADIX    = 78,
  parameter int MUL_LAT  = 3,
  parameter int TAG_W    = 4
) (
  input  logic                clk,
  input  logic                rst,
  mul_middle_issuer_if.slave  bus,
  output logic                mul_rst_n,
  output logic                mul_en,
  output logic [MUL_SIZE-1:0] mul_a,
  output logic [MUL_SIZE-1:0] mul_b,
  input  logic [RADIX-1:0]    mul_res,
  output logic                busy
`ifdef MUL_ISSUER_PERF_EN
  ,
  output logic [31:0]         op_count,
  output logic [31:0]         stall_count
`endif
);

  localparam int CNT_W = (MUL_LAT > 2) ? $clog2(MUL_LAT) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, CAPTURE} state_t;

  state_t           state;
  logic [CNT_W-1:0] wait_cnt;
  logic [TAG_W-1:0] tag_q;
  logic             out_valid_q;
  logic [RADIX-1:0] out_res_q;
  logic [TAG_W-1:0] out_tag_q;
  logic             xfer;

  // A new op may enter only when idle and the result slot is free or draining this edge.
  assign bus.in_ready  = (state == IDLE) && (!out_valid_q || bus.out_ready);
  assign xfer          = bus.in_valid && bus.in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_res   = out_res_q;
  assign bus.out_tag   = out_tag_q;
  assign busy          = (state != IDLE) || out_valid_q;
  assign mul_rst_n     = ~rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      wait_cnt    <= '0;
      tag_q       <= '0;
      out_valid_q <= 1'b0;
      out_res_q   <= '0;
      out_tag_q   <= '0;
      mul_en      <= 1'b0;
      mul_a       <= '0;
      mul_b       <= '0;
    end else begin
      mul_en <= 1'b0;
      if (out_valid_q && bus.out_ready) out_valid_q <= 1'b0;
      case (state)
        IDLE: begin
          if (xfer) begin
            mul_a  <= bus.in_a;
            mul_b  <= bus.in_b;
            tag_q  <= bus.in_tag;
            mul_en <= 1'b1;
            state  <= ISSUE;
          end
        end
        ISSUE: begin
          wait_cnt <= CNT_W'(MUL_LAT - 2);
          state    <= WAIT;
        end
        WAIT: begin
          if (wait_cnt == '0) state <= CAPTURE;
          else wait_cnt <= wait_cnt - 1'b1;
        end
        CAPTURE: begin
          out_res_q   <= mul_res;
          out_tag_q   <= tag_q;
          out_valid_q <= 1'b1;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef MUL_ISSUER_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      op_count    <= '0;
      stall_count <= '0;
    end else begin
      if (state == CAPTURE) op_count <= op_count + 32'd1;
      if (out_valid_q && !bus.out_ready) stall_count <= stall_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mul_middle_issuer.sv
// Self-checking bench for mul_middle_issuer: a behavioural multiplier drives mul_res,
// and a transaction-level model predicts handshakes, mul_en timing and results.
module tb_mul_middle_issuer;
  localparam int MUL_SIZE = 80;
  localparam int RADIX    = 78;
  localparam int MUL_LAT  = 3;
  localparam int TAG_W    = 4;

  localparam logic [79:0] A_2_78 = 80'h1 << 78;
  localparam logic [79:0] A_2_79 = 80'h1 << 79;
  localparam logic [79:0] A_2_76 = 80'h1 << 76;
  localparam logic [79:0] A_ONES = {80{1'b1}};
  localparam logic [77:0] R_ONES = 78'h3FFF_FFFF_FFFF_FFFF_FFF8;
  localparam logic [77:0] R_2_77 = 78'h1 << 77;

  logic clk = 1'b0;
  logic rst;
  logic mul_rst_n, mul_en, busy;
  logic [MUL_SIZE-1:0] mul_a, mul_b;
  logic [RADIX-1:0] mul_res;
`ifdef MUL_ISSUER_PERF_EN
  logic [31:0] op_count, stall_count;
`endif

  mul_middle_issuer_if #(.MUL_SIZE(MUL_SIZE), .RADIX(RADIX), .TAG_W(TAG_W)) bus ();

  mul_middle_issuer #(.MUL_SIZE(MUL_SIZE), .RADIX(RADIX), .MUL_LAT(MUL_LAT), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .mul_rst_n(mul_rst_n), .mul_en(mul_en), .mul_a(mul_a), .mul_b(mul_b),
    .mul_res(mul_res), .busy(busy)
`ifdef MUL_ISSUER_PERF_EN
    , .op_count(op_count), .stall_count(stall_count)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [77:0] middle(input logic [79:0] a, input logic [79:0] b);
    logic [159:0] p;
    p = 160'(a) * 160'(b);
    return p[155:78];
  endfunction

  // Multiplier stand-in: garbage until MUL_LAT edges after sampling en, then the true result.
  int          m_cnt;
  bit          m_have;
  logic [77:0] m_val, junk;
  always @(posedge clk) begin
    junk <= 78'({$urandom, $urandom, $urandom});
    if (!mul_rst_n) begin
      m_have <= 1'b0;
      m_cnt  <= 0;
    end else if (mul_en) begin
      m_val  <= middle(mul_a, mul_b);
      m_cnt  <= MUL_LAT - 1;
      m_have <= 1'b1;
    end else if (m_cnt != 0) begin
      m_cnt <= m_cnt - 1;
    end
  end
  assign mul_res = (m_have && m_cnt == 0) ? m_val : junk;

  int checks = 0;
  int failures = 0;

  bit          known = 0;
  bit          m_busy = 0;
  int          t_xfer = 0;
  int          cyc = 0;
  logic [79:0] op_a, op_b;
  logic [77:0] op_res;
  logic [3:0]  op_tag;
  bit          slot_valid = 0;
  logic [77:0] slot_res;
  logic [3:0]  slot_tag;
  bit          last_xfer = 0;
  int          last_en = -100;
  int          en_gaps[$];
  logic [3:0]  tags_seen[$];
  int          valid_seen = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h cycle=%0d", tag, obs, exp, cyc);
    end
  endtask

  // One clock: compare DUT against the model at negedge, then advance the model over the edge.
  task automatic cycle();
    logic exp_ready, exp_en;
    @(negedge clk);
    last_xfer = 0;
    exp_ready = !m_busy && (!slot_valid || bus.out_ready);
    exp_en    = m_busy && (cyc == t_xfer + 1);
    if (known) begin
      check("in_ready", bus.in_ready, exp_ready);
      check("mul_en", mul_en, exp_en);
      check("out_valid", bus.out_valid, slot_valid);
      check("busy", busy, m_busy || slot_valid);
      check("mul_rst_n", mul_rst_n, !rst);
      if (slot_valid) begin
        check("out_res", bus.out_res, slot_res);
        check("out_tag", bus.out_tag, slot_tag);
      end
      if (exp_en) begin
        check("mul_a", mul_a, op_a);
        check("mul_b", mul_b, op_b);
      end
      if (mul_en === 1'b1) begin
        if (last_en >= 0) begin
          check("en_gap_min", (cyc - last_en) >= MUL_LAT + 2, 1'b1);
          en_gaps.push_back(cyc - last_en);
        end
        last_en = cyc;
      end
      if (bus.out_valid === 1'b1) valid_seen++;
      if (bus.out_valid === 1'b1 && bus.out_ready) tags_seen.push_back(bus.out_tag);
    end
    if (rst) begin
      known      = 1;
      m_busy     = 0;
      slot_valid = 0;
      last_en    = -100;
    end else begin
      if (slot_valid && bus.out_ready) slot_valid = 0;
      if (m_busy && cyc == t_xfer + MUL_LAT + 1) begin
        slot_valid = 1;
        slot_res   = op_res;
        slot_tag   = op_tag;
        m_busy     = 0;
      end
      if (bus.in_valid && exp_ready) begin
        last_xfer = 1;
        m_busy    = 1;
        t_xfer    = cyc;
        op_a      = bus.in_a;
        op_b      = bus.in_b;
        op_tag    = bus.in_tag;
        op_res    = middle(bus.in_a, bus.in_b);
      end
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic send_until_accepted(input string name);
    int i;
    i = 0;
    bus.in_valid = 1'b1;
    do begin
      cycle();
      i++;
    end while (!last_xfer && i < 40);
    check({name, "_accepted"}, last_xfer, 1'b1);
  endtask

  task automatic run_op(input string name, input logic [79:0] a, input logic [79:0] b,
                        input logic [3:0] tag, input logic [77:0] exp_res);
    bus.in_a = a;
    bus.in_b = b;
    bus.in_tag = tag;
    bus.out_ready = 1'b1;
    send_until_accepted(name);
    bus.in_valid = 1'b0;
    repeat (MUL_LAT + 1) cycle();
    check({name, "_valid"}, bus.out_valid, 1'b1);
    check({name, "_res"}, bus.out_res, exp_res);
    check({name, "_tag"}, bus.out_tag, tag);
    cycle();
  endtask

  task automatic drain(input string name);
    int i;
    i = 0;
    while ((m_busy || slot_valid) && i < 200) begin
      cycle();
      i++;
    end
    check({name, "_drained"}, m_busy || slot_valid, 1'b0);
  endtask

  initial begin
    logic [77:0] held_res;
    logic [3:0]  held_tag;
    int          n, seen0, sent;

    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_a = '0;
    bus.in_b = '0;
    bus.in_tag = '0;
    bus.out_ready = 1'b0;
    repeat (3) cycle();
    rst = 1'b0;
    check("rst_mul_a", mul_a, 80'h0);
    check("rst_mul_b", mul_b, 80'h0);
    check("rst_out_res", bus.out_res, 78'h0);
    check("rst_out_tag", bus.out_tag, 4'h0);
    cycle();

    run_op("single", A_2_78, 80'h1, 4'd5, 78'h1);
    run_op("topbit", A_2_79, A_2_76, 4'd6, R_2_77);
    run_op("topsq", A_2_79, A_2_79, 4'd7, 78'h0);
    run_op("ones", A_ONES, A_ONES, 4'd8, R_ONES);

    // Back-to-back stream with in_valid held and no backpressure.
    tags_seen.delete();
    en_gaps.delete();
    last_en = -100;
    n = 0;
    bus.out_ready = 1'b1;
    bus.in_a = 80'({$urandom, $urandom, $urandom});
    bus.in_b = 80'({$urandom, $urandom, $urandom});
    bus.in_tag = 4'd0;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 80 && !(n == 4 && !m_busy && !slot_valid); i++) begin
      cycle();
      if (last_xfer) begin
        n++;
        if (n < 4) begin
          bus.in_a = 80'({$urandom, $urandom, $urandom});
          bus.in_b = 80'({$urandom, $urandom, $urandom});
          bus.in_tag = 4'(n);
        end else begin
          bus.in_valid = 1'b0;
        end
      end
    end
    check("b2b_results", tags_seen.size(), 4);
    for (int k = 0; k < tags_seen.size(); k++) check("b2b_tag_order", tags_seen[k], 4'(k));
    check("b2b_gap_count", en_gaps.size(), 3);
    for (int k = 0; k < en_gaps.size(); k++) check("b2b_en_gap", en_gaps[k], MUL_LAT + 2);

    // Backpressure: result held for 10 cycles while the next op waits.
    bus.out_ready = 1'b0;
    bus.in_a = A_2_78;
    bus.in_b = 80'd3;
    bus.in_tag = 4'd9;
    send_until_accepted("bp_first");
    bus.in_a = A_2_79;
    bus.in_b = A_2_76;
    bus.in_tag = 4'd10;
    for (int i = 0; i < 20 && !slot_valid; i++) cycle();
    held_res = bus.out_res;
    held_tag = bus.out_tag;
    check("bp_res", held_res, 78'h3);
    check("bp_tag", held_tag, 4'd9);
    for (int i = 0; i < 10; i++) begin
      cycle();
      check("bp_res_stable", bus.out_res, held_res);
      check("bp_tag_stable", bus.out_tag, held_tag);
      check("bp_in_ready_low", bus.in_ready, 1'b0);
    end
    bus.out_ready = 1'b1;
    #1;
    check("bp_release_ready", bus.in_ready, 1'b1);
    cycle();
    check("bp_same_edge_accept", last_xfer, 1'b1);
    bus.in_valid = 1'b0;
    repeat (MUL_LAT + 1) cycle();
    check("bp_second_res", bus.out_res, R_2_77);
    drain("bp");

    // Reset during WAIT discards the in-flight op.
    bus.in_a = A_ONES;
    bus.in_b = A_ONES;
    bus.in_tag = 4'd11;
    send_until_accepted("abort");
    bus.in_valid = 1'b0;
    cycle();
    cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    check("abort_mul_en", mul_en, 1'b0);
    check("abort_out_valid", bus.out_valid, 1'b0);
    check("abort_mul_a", mul_a, 80'h0);
    seen0 = valid_seen;
    repeat (8) cycle();
    check("abort_no_result", valid_seen - seen0, 0);
    run_op("after_abort", A_2_78, 80'h1, 4'd12, 78'h1);

    // Randomised traffic with random backpressure.
    sent = 0;
    bus.in_valid = 1'b0;
    for (int i = 0; i < 3000 && sent < 25; i++) begin
      bus.out_ready = 1'($urandom_range(0, 1));
      if (!bus.in_valid && $urandom_range(0, 2) != 0) begin
        bus.in_a = ($urandom_range(0, 5) == 0) ? A_ONES : 80'({$urandom, $urandom, $urandom});
        bus.in_b = 80'({$urandom, $urandom, $urandom});
        bus.in_tag = 4'($urandom);
        bus.in_valid = 1'b1;
      end
      cycle();
      if (last_xfer) begin
        bus.in_valid = 1'b0;
        sent++;
      end
    end
    check("rand_sent", sent, 25);
    bus.out_ready = 1'b1;
    drain("rand");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
